// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// hazard_forward_unit : tag pipeline, forwarding selects, load-use stall
// Revision 1.0
// ============================================================================
module hazard_forward_unit #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rn_i,
  input  logic [REG_W-1:0] id_rm_i,
  input  logic             id_rn_used_i,
  input  logic             id_rm_used_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             id_alusrc_i,
  input  logic             flush_i,
  output logic [1:0]       forward_a_o,
  output logic [1:0]       forward_b_o,
  output logic [1:0]       forward_store_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam logic [REG_W-1:0] C_ZERO_TAG = REG_W'(ZERO_REG);
  localparam logic [1:0]       C_FWD_RF   = 2'b00;
  localparam logic [1:0]       C_FWD_MEM  = 2'b10;
  localparam logic [1:0]       C_FWD_WB   = 2'b01;

  logic             ex_valid_q, ex_regwrite_q, ex_memread_q, ex_alusrc_q;
  logic             ex_rn_used_q, ex_rm_used_q;
  logic [REG_W-1:0] ex_rd_q, ex_rn_q, ex_rm_q;
  logic             mem_valid_q, mem_regwrite_q;
  logic [REG_W-1:0] mem_rd_q;
  logic             wb_valid_q, wb_regwrite_q;
  logic [REG_W-1:0] wb_rd_q;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic             w_stall;
  logic [1:0]       w_fwd_a, w_fwd_store;

  function automatic logic stage_hits(
    input logic             v,
    input logic             rw,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] r
  );
    return v & rw & (rd == r) & (rd != C_ZERO_TAG);
  endfunction

  always_comb begin
    w_stall = id_valid_i & ex_valid_q & ex_memread_q &
              ((id_rn_used_i & stage_hits(ex_valid_q, ex_regwrite_q, ex_rd_q, id_rn_i)) |
               (id_rm_used_i & stage_hits(ex_valid_q, ex_regwrite_q, ex_rd_q, id_rm_i)));
    if (flush_i) begin
      w_stall = 1'b0;
    end
  end

  // MEM holds the younger result, so it is checked before WB.
  always_comb begin
    w_fwd_a = C_FWD_RF;
    if (ex_rn_used_q && stage_hits(mem_valid_q, mem_regwrite_q, mem_rd_q, ex_rn_q)) begin
      w_fwd_a = C_FWD_MEM;
    end else if (ex_rn_used_q && stage_hits(wb_valid_q, wb_regwrite_q, wb_rd_q, ex_rn_q)) begin
      w_fwd_a = C_FWD_WB;
    end
  end

  always_comb begin
    w_fwd_store = C_FWD_RF;
    if (ex_rm_used_q && stage_hits(mem_valid_q, mem_regwrite_q, mem_rd_q, ex_rm_q)) begin
      w_fwd_store = C_FWD_MEM;
    end else if (ex_rm_used_q && stage_hits(wb_valid_q, wb_regwrite_q, wb_rd_q, ex_rm_q)) begin
      w_fwd_store = C_FWD_WB;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (w_stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_alusrc_q    <= 1'b0;
      ex_rn_used_q   <= 1'b0;
      ex_rm_used_q   <= 1'b0;
      ex_rd_q        <= '0;
      ex_rn_q        <= '0;
      ex_rm_q        <= '0;
      mem_valid_q    <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_rd_q       <= '0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_rd_q        <= '0;
      stall_count_q  <= '0;
    end else begin
      wb_valid_q     <= mem_valid_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_rd_q        <= mem_rd_q;
      mem_valid_q    <= ex_valid_q & ~flush_i;
      mem_regwrite_q <= ex_regwrite_q;
      mem_rd_q       <= ex_rd_q;
      // A stalled or flushed slot still captures the ID fields but enters EX as a bubble.
      ex_valid_q     <= id_valid_i & ~w_stall & ~flush_i;
      ex_regwrite_q  <= id_regwrite_i;
      ex_memread_q   <= id_memread_i;
      ex_alusrc_q    <= id_alusrc_i;
      ex_rn_used_q   <= id_rn_used_i;
      ex_rm_used_q   <= id_rm_used_i;
      ex_rd_q        <= id_rd_i;
      ex_rn_q        <= id_rn_i;
      ex_rm_q        <= id_rm_i;
      stall_count_q  <= stall_count_d;
    end
  end

  assign forward_a_o     = w_fwd_a;
  assign forward_store_o = w_fwd_store;
  assign forward_b_o     = ex_alusrc_q ? C_FWD_RF : w_fwd_store;
  assign stall_o         = w_stall;
  assign stall_count_o   = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_forward_unit : directed checks of forwarding, stall and flush
// Revision 1.0
// ============================================================================
module tb_hazard_forward_unit;

  localparam int C_REG_W = 5;
  // Narrow counter so saturation is reachable in a short run.
  localparam int C_CNT_W = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               id_valid, id_rn_used, id_rm_used, id_regwrite, id_memread, id_alusrc;
  logic [C_REG_W-1:0] id_rn, id_rm, id_rd;
  logic               flush;
  logic [1:0]         forward_a, forward_b, forward_store;
  logic               stall;
  logic [C_CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  hazard_forward_unit #(
    .REG_W   (C_REG_W),
    .ZERO_REG(31),
    .CNT_W   (C_CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid_i     (id_valid),
    .id_rn_i        (id_rn),
    .id_rm_i        (id_rm),
    .id_rn_used_i   (id_rn_used),
    .id_rm_used_i   (id_rm_used),
    .id_rd_i        (id_rd),
    .id_regwrite_i  (id_regwrite),
    .id_memread_i   (id_memread),
    .id_alusrc_i    (id_alusrc),
    .flush_i        (flush),
    .forward_a_o    (forward_a),
    .forward_b_o    (forward_b),
    .forward_store_o(forward_store),
    .stall_o        (stall),
    .stall_count_o  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic v, input int rn, input int rm, input logic rnu,
                        input logic rmu, input int rd, input logic rw, input logic mr,
                        input logic as);
    id_valid    = v;
    id_rn       = C_REG_W'(rn);
    id_rm       = C_REG_W'(rm);
    id_rn_used  = rnu;
    id_rm_used  = rmu;
    id_rd       = C_REG_W'(rd);
    id_regwrite = rw;
    id_memread  = mr;
    id_alusrc   = as;
  endtask

  task automatic set_nop();
    set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush = 1'b0;
    set_nop();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    set_id(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0);
    #2;
    checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL reset_fa: got %b expected 00", forward_a); end
    checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL reset_fb: got %b expected 00", forward_b); end
    checks++; if (forward_store !== 2'b00) begin errors++; $display("FAIL reset_fs: got %b expected 00", forward_store); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (stall_count !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_count); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1'b1, 0, 0, 1'b1, 1'b0, 7, 1'b1, 1'b1, 1'b1); step();   // LDUR X7,[X0]
    set_id(1'b1, 7, 7, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0); step();   // ADD X8,X7,X7 (stalls)
    set_id(1'b1, 2, 3, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0); step();   // ADD X1,X2,X3
    set_id(1'b1, 1, 0, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b1); step();   // LDUR X4,[X1]
    set_id(1'b1, 4, 4, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0);           // SUB X5,X4,X4
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %b expected 1", stall); end
    checks++; if (forward_a !== 2'b10) begin errors++; $display("FAIL mid_pre_fa: got %b expected 10", forward_a); end
    checks++; if (stall_count !== 6'd1) begin errors++; $display("FAIL mid_pre_cnt: got %0d expected 1", stall_count); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall: got %b expected 0", stall); end
    checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL mid_rst_fa: got %b expected 00", forward_a); end
    checks++; if (stall_count !== '0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", stall_count); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_ex_mem_forward();
    do_reset();
    set_id(1'b1, 2, 3, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0); step();   // ADD X1,X2,X3
    set_id(1'b1, 1, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0); step();   // SUB X4,X1,X5
    set_nop();
    @(negedge clk);
    checks++; if (forward_a !== 2'b10) begin errors++; $display("FAIL exmem_fa: got %b expected 10", forward_a); end
    checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL exmem_fb: got %b expected 00", forward_b); end
  endtask

  task automatic test_wb_forward();
    do_reset();
    set_id(1'b1, 2, 3, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0); step();    // ADD X1,X2,X3
    set_id(1'b1, 11, 12, 1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b0); step(); // ORR X10,X11,X12
    set_id(1'b1, 7, 1, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0); step();    // AND X6,X7,X1
    set_nop();
    @(negedge clk);
    checks++; if (forward_b !== 2'b01) begin errors++; $display("FAIL wb_fb: got %b expected 01", forward_b); end
    checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL wb_fa: got %b expected 00", forward_a); end
    checks++; if (forward_store !== 2'b01) begin errors++; $display("FAIL wb_fs: got %b expected 01", forward_store); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 10, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b1); step();   // LDUR X2,[X10]
    set_id(1'b1, 2, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0);            // ADD X3,X2,X2
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", stall); end
    checks++; if (stall_count !== 6'd0) begin errors++; $display("FAIL lu_cnt0: got %0d expected 0", stall_count); end
    step();
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_drop: got %b expected 0", stall); end
    checks++; if (stall_count !== 6'd1) begin errors++; $display("FAIL lu_cnt1: got %0d expected 1", stall_count); end
    step();
    set_nop();
    @(negedge clk);
    checks++; if (forward_a !== 2'b01) begin errors++; $display("FAIL lu_fa: got %b expected 01", forward_a); end
    checks++; if (forward_b !== 2'b01) begin errors++; $display("FAIL lu_fb: got %b expected 01", forward_b); end
    checks++; if (stall_count !== 6'd1) begin errors++; $display("FAIL lu_cnt_hold: got %0d expected 1", stall_count); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_id(1'b1, 2, 3, 1'b1, 1'b1, 31, 1'b1, 1'b0, 1'b0); step();   // ADD X31,X2,X3
    set_id(1'b1, 31, 31, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0); step();  // ORR X8,X31,X31
    set_nop();
    @(negedge clk);
    checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL xzr_fa: got %b expected 00", forward_a); end
    checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL xzr_fb: got %b expected 00", forward_b); end
    checks++; if (forward_store !== 2'b00) begin errors++; $display("FAIL xzr_fs: got %b expected 00", forward_store); end
  endtask

  task automatic test_alusrc();
    do_reset();
    set_id(1'b1, 2, 3, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0); step();    // ADD X1,X2,X3
    set_id(1'b1, 1, 0, 1'b1, 1'b0, 9, 1'b1, 1'b0, 1'b1); step();    // ADDI X9,X1,#4
    set_id(1'b1, 2, 1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1);            // STUR X1,[X2]
    @(negedge clk);
    checks++; if (forward_a !== 2'b10) begin errors++; $display("FAIL addi_fa: got %b expected 10", forward_a); end
    checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL addi_fb: got %b expected 00", forward_b); end
    step();
    set_nop();
    @(negedge clk);
    checks++; if (forward_store !== 2'b01) begin errors++; $display("FAIL stur_fs: got %b expected 01", forward_store); end
    checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL stur_fb: got %b expected 00", forward_b); end
  endtask

  task automatic test_priority();
    do_reset();
    set_id(1'b1, 2, 3, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0); step();    // ADD X1,X2,X3
    set_id(1'b1, 4, 5, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0); step();    // SUB X1,X4,X5
    set_id(1'b1, 1, 1, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b0); step();    // AND X7,X1,X1
    set_nop();
    @(negedge clk);
    checks++; if (forward_a !== 2'b10) begin errors++; $display("FAIL prio_fa: got %b expected 10", forward_a); end
    checks++; if (forward_b !== 2'b10) begin errors++; $display("FAIL prio_fb: got %b expected 10", forward_b); end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1'b1, 10, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b1); step();   // LDUR X2,[X10]
    set_id(1'b1, 2, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0);            // ADD X3,X2,X2
    flush = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
    step();
    flush = 1'b0;
    set_id(1'b1, 3, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0); step();    // ORR X4,X3,X2
    set_nop();
    @(negedge clk);
    checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL flush_fa: got %b expected 00", forward_a); end
    checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL flush_fb: got %b expected 00", forward_b); end
    checks++; if (stall_count !== 6'd0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", stall_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 62; i++) begin
      set_id(1'b1, 0, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b1); step();
      set_id(1'b1, 2, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0); step();
    end
    set_nop();
    @(negedge clk);
    checks++; if (stall_count !== 6'd62) begin errors++; $display("FAIL sat_62: got %0d expected 62", stall_count); end
    for (int i = 0; i < 8; i++) begin
      set_id(1'b1, 0, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b1); step();
      set_id(1'b1, 2, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0); step();
    end
    set_nop();
    @(negedge clk);
    checks++; if (stall_count !== 6'h3F) begin errors++; $display("FAIL sat_max: got %0d expected 63", stall_count); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_stall();
    test_ex_mem_forward();
    test_wb_forward();
    test_load_use();
    test_zero_reg();
    test_alusrc();
    test_priority();
    test_flush();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
